// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding,
// default start timeout and an index-width helper.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DRAIN = 2'd2
  } uart_arb_state_t;

  localparam int DEFAULT_START_TIMEOUT = 16;

  // Width of an index into n requesters; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Producer/transmitter side bundle of the UART transmit arbiter.
// slave: the arbiter's view; master: the producers plus UART transmitter.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_BITS = 8
);

  logic [NUM_REQ-1:0]           Req;
  logic [NUM_REQ*DATA_BITS-1:0] Req_Data;
  logic [NUM_REQ-1:0]           Grant;
  logic [DATA_BITS-1:0]         Tx_Data;
  logic                         Transmit_Start;
  logic                         Tx_Busy;
  logic                         Arb_Busy;
  logic                         Start_Timeout;

  modport slave (
    input  Req,
    input  Req_Data,
    input  Tx_Busy,
    output Grant,
    output Tx_Data,
    output Transmit_Start,
    output Arb_Busy,
    output Start_Timeout
  );

  modport master (
    output Req,
    output Req_Data,
    output Tx_Busy,
    input  Grant,
    input  Tx_Data,
    input  Transmit_Start,
    input  Arb_Busy,
    input  Start_Timeout
  );

endinterface

// File: rtl/uart_rr_pick.sv
// Combinational rotating-priority selector: the first set request found
// scanning upward from last+1, wrapping modulo NUM_REQ.
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]              Req,
  input  logic [idx_width(NUM_REQ)-1:0]   last,
  output logic                            valid,
  output logic [idx_width(NUM_REQ)-1:0]   idx,
  output logic [NUM_REQ-1:0]              onehot
);

  localparam int IDX_W = idx_width(NUM_REQ);

  // Scan the NUM_REQ positions after last; the first hit wins.
  always_comb begin
    valid  = 1'b0;
    idx    = '0;
    onehot = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int                cand;
      logic [IDX_W-1:0]  cand_idx;
      cand = int'(last) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!valid && Req[cand_idx]) begin
        valid            = 1'b1;
        idx              = cand_idx;
        onehot[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte
// producers. Grants a requester, registers its byte onto Tx_Data and holds
// Transmit_Start until the transmitter reports busy or a timeout expires.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int DATA_BITS     = 8,
  parameter int START_TIMEOUT = DEFAULT_START_TIMEOUT
) (
  input  logic             SysClk,
  input  logic             Rst,
  uart_tx_arbiter_if.slave bus
);

  localparam int IDX_W = idx_width(NUM_REQ);
  localparam int CNT_W = $clog2(START_TIMEOUT);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_START = START;
  localparam logic [1:0] ST_DRAIN = DRAIN;

  localparam logic [IDX_W-1:0] LAST_RESET = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(START_TIMEOUT - 1);

  logic [1:0]           state;
  logic [IDX_W-1:0]     last;
  logic [CNT_W-1:0]     cnt;

  logic                 pick_valid;
  logic [IDX_W-1:0]     pick_idx;
  logic [NUM_REQ-1:0]   pick_onehot;
  logic [DATA_BITS-1:0] pick_data;

  // Saturating increment: the start counter must never wrap back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .Req    (bus.Req),
    .last   (last),
    .valid  (pick_valid),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  // Byte of the selected requester, or-reduced through the one-hot select.
  always_comb begin
    pick_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_onehot[i]) pick_data = pick_data | bus.Req_Data[i*DATA_BITS +: DATA_BITS];
    end
  end

  // Arbitration FSM, start-hold counter and registered transmitter outputs.
  always_ff @(posedge SysClk) begin
    if (Rst) begin
      state              <= ST_IDLE;
      last               <= LAST_RESET;
      cnt                <= '0;
      bus.Grant          <= '0;
      bus.Tx_Data        <= '0;
      bus.Transmit_Start <= 1'b0;
      bus.Start_Timeout  <= 1'b0;
    end else begin
      bus.Grant         <= '0;
      bus.Start_Timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          // A busy transmitter here belongs to another agent (or a frame that
          // survived reset); never start on top of it.
          if (!bus.Tx_Busy && pick_valid) begin
            bus.Grant          <= pick_onehot;
            bus.Tx_Data        <= pick_data;
            bus.Transmit_Start <= 1'b1;
            last               <= pick_idx;
            cnt                <= '0;
            state              <= ST_START;
          end
        end
        ST_START: begin
          if (bus.Tx_Busy) begin
            bus.Transmit_Start <= 1'b0;
            state              <= ST_DRAIN;
          end else if (cnt == CNT_LAST) begin
            // Transmitter never answered: drop the byte, no retry.
            bus.Transmit_Start <= 1'b0;
            bus.Start_Timeout  <= 1'b1;
            state              <= ST_IDLE;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        ST_DRAIN: begin
          if (!bus.Tx_Busy) state <= ST_IDLE;
        end
        default: begin
          bus.Transmit_Start <= 1'b0;
          state              <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.Arb_Busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: directed scenarios followed by randomized
// traffic, all outputs compared every cycle against a transaction-level model.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int DB = 8;
  localparam int TO = 16;

  logic SysClk = 1'b0;
  logic Rst;

  uart_tx_arbiter_if #(.NUM_REQ(N), .DATA_BITS(DB)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ       (N),
    .DATA_BITS     (DB),
    .START_TIMEOUT (TO)
  ) dut (
    .SysClk (SysClk),
    .Rst    (Rst),
    .bus    (bus.slave)
  );

  always #5 SysClk = ~SysClk;

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 = waiting, 1 = strobing start, 2 = frame in flight
  int            m_phase;
  int            m_last;
  int            m_hold;      // cycles Transmit_Start has been high so far
  logic [N-1:0]  m_grant;
  logic [DB-1:0] m_txd;
  logic          m_ts;
  logic          m_to;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs that edge sampled.
  task automatic model_step();
    if (Rst) begin
      m_phase = 0; m_last = N - 1; m_hold = 0;
      m_grant = '0; m_txd = '0; m_ts = 1'b0; m_to = 1'b0;
    end else begin
      m_grant = '0;
      m_to    = 1'b0;
      if (m_phase == 0) begin
        if (!bus.Tx_Busy && bus.Req != '0) begin
          bit found = 1'b0;
          for (int k = 1; k <= N; k++) begin
            int i = (m_last + k) % N;
            if (!found && bus.Req[i]) begin
              found    = 1'b1;
              m_grant  = N'(1) << i;
              m_txd    = DB'(bus.Req_Data >> (i * DB));
              m_last   = i;
            end
          end
          m_ts = 1'b1; m_hold = 1; m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (bus.Tx_Busy) begin
          m_ts = 1'b0; m_phase = 2;
        end else if (m_hold == TO) begin
          m_ts = 1'b0; m_to = 1'b1; m_phase = 0;
        end else begin
          m_hold++;
        end
      end else begin
        if (!bus.Tx_Busy) m_phase = 0;
      end
    end
  endtask

  // One clock: update the model on the edge, compare just after it.
  task automatic cycle();
    @(posedge SysClk);
    model_step();
    #1;
    check_eq("grant",   32'(bus.Grant),          32'(m_grant));
    check_eq("tx_data", 32'(bus.Tx_Data),        32'(m_txd));
    check_eq("tstart",  32'(bus.Transmit_Start), 32'(m_ts));
    check_eq("arbbusy", 32'(bus.Arb_Busy),       32'(m_phase != 0));
    check_eq("timeout", 32'(bus.Start_Timeout),  32'(m_to));
  endtask

  int  ts_cnt;
  bit  to_seen;
  int  ub, ud, ext;
  bit  dead;

  initial begin
    Rst          = 1'b1;
    bus.Req      = '0;
    bus.Req_Data = '0;
    bus.Tx_Busy  = 1'b0;
    repeat (2) cycle();
    check_eq("rst_grant", 32'(bus.Grant), 32'h0);
    check_eq("rst_ts",    32'(bus.Transmit_Start), 32'h0);
    check_eq("rst_data",  32'(bus.Tx_Data), 32'h0);
    Rst = 1'b0;

    // Single request, busy answers on the third start cycle
    bus.Req_Data[7:0] = 8'hA5;
    bus.Req = 4'b0001;
    cycle();
    check_eq("t1_grant", 32'(bus.Grant), 32'h1);
    check_eq("t1_data",  32'(bus.Tx_Data), 32'hA5);
    bus.Req = '0;
    ts_cnt = 1;
    repeat (2) begin cycle(); if (bus.Transmit_Start) ts_cnt++; end
    bus.Tx_Busy = 1'b1;
    cycle(); if (bus.Transmit_Start) ts_cnt++;
    check_eq("t1_ts_len", 32'(ts_cnt), 32'd3);
    check_eq("t1_drain",  32'(bus.Arb_Busy), 32'h1);
    repeat (4) cycle();
    bus.Tx_Busy = 1'b0;
    cycle();
    check_eq("t1_idle", 32'(bus.Arb_Busy), 32'h0);

    // Start timeout with the transmitter stuck idle
    bus.Req_Data[15:8] = 8'h5A;
    bus.Req = 4'b0010;
    cycle();
    check_eq("to_grant", 32'(bus.Grant), 32'h2);
    bus.Req = '0;
    ts_cnt = 1; to_seen = 1'b0;
    for (int c = 0; c < 20 && !to_seen; c++) begin
      cycle();
      if (bus.Transmit_Start) ts_cnt++;
      if (bus.Start_Timeout) to_seen = 1'b1;
    end
    check_eq("to_seen",   32'(to_seen), 32'h1);
    check_eq("to_ts_len", 32'(ts_cnt), 32'd16);
    bus.Req_Data[23:16] = 8'h33;
    bus.Req = 4'b0110;
    cycle();
    check_eq("to_next", 32'(bus.Grant), 32'h4);
    bus.Req = '0;
    bus.Tx_Busy = 1'b1;
    cycle();

    // Reset while a frame is in flight
    Rst = 1'b1;
    cycle();
    Rst = 1'b0;
    check_eq("mr_grant", 32'(bus.Grant), 32'h0);
    check_eq("mr_data",  32'(bus.Tx_Data), 32'h0);
    check_eq("mr_busy",  32'(bus.Arb_Busy), 32'h0);
    bus.Req_Data = {8'h44, 8'h33, 8'h22, 8'h11};
    bus.Req = 4'b1010;
    cycle();
    check_eq("mr_wait", 32'(bus.Grant), 32'h0);
    bus.Tx_Busy = 1'b0;
    cycle();
    check_eq("mr_first", 32'(bus.Grant), 32'h2);
    check_eq("mr_fdata", 32'(bus.Tx_Data), 32'h22);
    bus.Req = '0;
    bus.Tx_Busy = 1'b1;
    cycle();

    // Request pulsed and withdrawn during a frame is forgotten
    bus.Req = 4'b1000;
    cycle();
    bus.Req = '0;
    cycle();
    bus.Tx_Busy = 1'b0;
    repeat (4) cycle();
    check_eq("drop_idle", 32'(bus.Arb_Busy), 32'h0);

    // Randomized traffic with a modelled UART, external busy and resets
    ub = 0; ud = -1; ext = 0; dead = 1'b0;
    for (int t = 0; t < 4000; t++) begin
      Rst = ($urandom_range(399, 0) == 0);
      if ($urandom_range(299, 0) == 0) dead = ~dead;
      for (int i = 0; i < N; i++) begin
        if (bus.Req[i] && m_grant[i]) begin
          if ($urandom_range(1, 0) == 1) bus.Req[i] = 1'b0;
          else bus.Req_Data[i*DB +: DB] = DB'($urandom);
        end else if (bus.Req[i]) begin
          if ($urandom_range(39, 0) == 0) bus.Req[i] = 1'b0;
        end else if ($urandom_range(3, 0) == 0) begin
          bus.Req[i] = 1'b1;
          bus.Req_Data[i*DB +: DB] = DB'($urandom);
        end
      end
      if (ub > 0) ub--;
      if (ud > 0) ud--;
      else if (ud == 0) begin ub = $urandom_range(12, 2); ud = -1; end
      if (bus.Transmit_Start && ub == 0 && ud < 0 && !dead) ud = $urandom_range(2, 0);
      if (ext > 0) ext--;
      else if (!bus.Arb_Busy && $urandom_range(19, 0) == 0) ext = $urandom_range(4, 1);
      bus.Tx_Busy = (ub > 0) || (ext > 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
